// File: rtl/axil_rd_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ read requesters onto one AXI4-Lite
// read master port, with at most one transaction outstanding.
module axil_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          resp_valid,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_err,
  output logic [ADDR_WIDTH-1:0]         ARADDR,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  input  logic [DATA_WIDTH-1:0]         RDATA,
  input  logic [1:0]                    RRESP,
  input  logic                          RVALID,
  output logic                          RREADY,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ID_WIDTH-1:0]   last_grant;
  logic [ID_WIDTH-1:0]   id_q;

  logic [NUM_REQ-1:0]    grant_hi, grant_lo, grant;
  logic [ID_WIDTH-1:0]   win_hi, win_lo, win_id;
  logic [ADDR_WIDTH-1:0] addr_hi, addr_lo, win_addr;
  logic                  accept;

  // Round-robin search split into two passes: requesters above last_grant
  // take priority over those at or below it, which gives the wrap-around order
  // without modulo arithmetic and never touches an index >= NUM_REQ.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    win_hi   = '0;
    win_lo   = '0;
    addr_hi  = '0;
    addr_lo  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (i > 32'(last_grant)) begin
          if (grant_hi == '0) begin
            grant_hi[i] = 1'b1;
            win_hi      = ID_WIDTH'(i);
            addr_hi     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          end
        end else if (grant_lo == '0) begin
          grant_lo[i] = 1'b1;
          win_lo      = ID_WIDTH'(i);
          addr_lo     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
    end
    if (grant_hi != '0) begin
      grant    = grant_hi;
      win_id   = win_hi;
      win_addr = addr_hi;
    end else begin
      grant    = grant_lo;
      win_id   = win_lo;
      win_addr = addr_lo;
    end
  end

  // Gating with rst keeps req_ready low while reset is asserted even if
  // requesters are already driving req_valid.
  assign req_ready = (state == IDLE && rst) ? grant : '0;
  assign accept    = (req_ready != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
      id_q       <= '0;
      ARADDR     <= '0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= win_id;
        id_q       <= win_id;
        ARADDR     <= win_addr;
      end
      if (state == DATA && RVALID) begin
        resp_id   <= id_q;
        resp_data <= RDATA;
        resp_err  <= (RRESP != 2'b00);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = ADDR;
      end
      ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = DATA;
      end
      DATA: begin
        RREADY = 1'b1;
        if (RVALID) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Scoreboard bench for axil_rd_arbiter: stimulus queues expected grants,
// addresses and responses; a negedge monitor pops and compares them.
module tb_axil_rd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int IW      = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic [IW-1:0]         resp_id;
  logic [DW-1:0]         resp_data;
  logic                  resp_err;
  logic [AW-1:0]         ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DW-1:0]         RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;
  logic                  busy;

  axil_rd_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ID_WIDTH  (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_id   (resp_id),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .ARADDR    (ARADDR),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          err;
  } resp_t;

  int            exp_grant[$];
  logic [AW-1:0] exp_addr[$];
  resp_t         exp_resp[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    chk_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
  endtask

  task automatic fail_msg(input string name);
    chk_cnt++;
    $display("FAIL %s: got event missing/unexpected, expected none", name);
  endtask

  // Slave model: optional stall counts on ARREADY and RVALID.
  int            ar_delay = 0, r_delay = 0, ar_wait = 0, r_wait = 0;
  logic [DW-1:0] rdata_v = '0;
  logic [1:0]    rresp_v = 2'b00;

  initial begin
    ARREADY = 1'b1;
    RVALID  = 1'b1;
    RDATA   = '0;
    RRESP   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      RDATA = rdata_v;
      RRESP = rresp_v;
      if (ARVALID) begin
        if (ar_delay == 0) ARREADY = 1'b1;
        else if (ar_wait < ar_delay) begin ARREADY = 1'b0; ar_wait++; end
        else ARREADY = 1'b1;
      end else begin
        ARREADY = (ar_delay == 0);
        ar_wait = 0;
      end
      if (RREADY) begin
        if (r_delay == 0) RVALID = 1'b1;
        else if (r_wait < r_delay) begin RVALID = 1'b0; r_wait++; end
        else RVALID = 1'b1;
      end else begin
        RVALID = (r_delay == 0);
        r_wait = 0;
      end
    end
  end

  // Monitor
  int    grant_seen = 0, resp_seen = 0, arv_cyc = 0, rr_cyc = 0, last_gcyc = 0;
  int    mon_idx;
  bit    have_prev = 0, lat_check = 0;
  resp_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (req_ready != '0) begin
          mon_idx = -1;
          for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) mon_idx = i;
          check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
          if (exp_grant.size() == 0) fail_msg("unexpected_grant");
          else check("grant_id", 64'(mon_idx), 64'(exp_grant.pop_front()));
          if (lat_check && have_prev) check("accept_spacing", 64'(cyc - last_gcyc), 64'd4);
          last_gcyc = cyc;
          have_prev = 1;
          grant_seen++;
        end
        if (ARVALID) begin
          arv_cyc++;
          if (exp_addr.size() == 0) fail_msg("unexpected_arvalid");
          else begin
            check("araddr", 64'(ARADDR), 64'(exp_addr[0]));
            if (ARREADY) void'(exp_addr.pop_front());
          end
        end
        if (RREADY) rr_cyc++;
        if (resp_valid) begin
          if (exp_resp.size() == 0) fail_msg("unexpected_resp");
          else begin
            mon_e = exp_resp.pop_front();
            check("resp_id", 64'(resp_id), 64'(mon_e.id));
            check("resp_data", 64'(resp_data), 64'(mon_e.data));
            check("resp_err", 64'(resp_err), 64'(mon_e.err));
            if (lat_check) check("resp_latency", 64'(cyc - last_gcyc), 64'd3);
          end
          resp_seen++;
        end
      end
    end
  end

  task automatic push_txn(input int id, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic err);
    resp_t e;
    e.id   = IW'(id);
    e.data = data;
    e.err  = err;
    exp_grant.push_back(id);
    exp_addr.push_back(addr);
    exp_resp.push_back(e);
  endtask

  task automatic begin_test(input bit lat);
    lat_check = lat;
    have_prev = 0;
  endtask

  task automatic wait_grants(input int target, input int budget, input string name);
    int n = 0;
    do begin @(posedge clk); n++; end while (grant_seen < target && n < budget);
    if (grant_seen < target) fail_msg(name);
  endtask

  task automatic wait_resps(input int target, input int budget, input string name);
    int n = 0;
    do begin @(posedge clk); n++; end while (resp_seen < target && n < budget);
    if (resp_seen < target) fail_msg(name);
  endtask

  int g0, r0, n;

  initial begin
    // Reset with all requesters asserting: nothing may be granted.
    #1 rst = 1'b0;
    req_valid = 4'b1111;
    req_addr  = {32'h0000_0AAC, 32'h0000_0AA8, 32'h0000_0AA4, 32'h0000_0AA0};
    #2;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_arvalid", 64'(ARVALID), 64'd0);
    check("rst_rready", 64'(RREADY), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_araddr", 64'(ARADDR), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Contention: all four held, order 0,1,2,3,0.
    @(posedge clk); #1;
    begin_test(1);
    rdata_v = 32'h0BAD_F00D;
    push_txn(0, 32'h0000_0100, 32'h0BAD_F00D, 1'b0);
    push_txn(1, 32'h0000_0104, 32'h0BAD_F00D, 1'b0);
    push_txn(2, 32'h0000_0108, 32'h0BAD_F00D, 1'b0);
    push_txn(3, 32'h0000_010C, 32'h0BAD_F00D, 1'b0);
    push_txn(0, 32'h0000_0100, 32'h0BAD_F00D, 1'b0);
    g0 = grant_seen; r0 = resp_seen;
    req_addr  = {32'h0000_010C, 32'h0000_0108, 32'h0000_0104, 32'h0000_0100};
    req_valid = 4'b1111;
    wait_grants(g0 + 5, 40, "contention_grant_timeout");
    #1 req_valid = '0;
    wait_resps(r0 + 5, 20, "contention_resp_timeout");

    // Single request from requester 2.
    @(posedge clk); #1;
    begin_test(1);
    rdata_v = 32'hDEAD_BEEF;
    push_txn(2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    g0 = grant_seen; r0 = resp_seen;
    req_addr  = {32'hFFFF_0003, 32'h0000_0010, 32'hFFFF_0001, 32'hFFFF_0000};
    req_valid = 4'b0100;
    wait_grants(g0 + 1, 20, "single_grant_timeout");
    #1 req_valid = '0;
    wait_resps(r0 + 1, 20, "single_resp_timeout");
    @(posedge clk); #1;
    check("idle_busy", 64'(busy), 64'd0);

    // Backpressure on both channels; a late request during the stall must wait.
    begin_test(0);
    ar_delay = 5; r_delay = 7;
    rdata_v = 32'h5555_AAAA;
    push_txn(3, 32'hCAFE_0000, 32'h5555_AAAA, 1'b0);
    g0 = grant_seen; r0 = resp_seen;
    arv_cyc = 0; rr_cyc = 0;
    req_addr  = {32'hCAFE_0000, 32'h0000_0020, 32'h0000_0030, 32'h0000_0040};
    req_valid = 4'b1000;
    wait_grants(g0 + 1, 20, "bp_grant_timeout");
    #1 req_valid = '0;
    repeat (2) @(posedge clk);
    #1 req_valid = 4'b0100;
    repeat (2) @(posedge clk);
    #1 req_valid = '0;
    wait_resps(r0 + 1, 40, "bp_resp_timeout");
    repeat (5) @(posedge clk);
    check("bp_arvalid_cycles", 64'(arv_cyc), 64'd6);
    check("bp_rready_cycles", 64'(rr_cyc), 64'd8);
    check("bp_resp_count", 64'(resp_seen - r0), 64'd1);
    #1 ar_delay = 0; r_delay = 0;

    // Error response; data and flags hold afterwards.
    @(posedge clk); #1;
    begin_test(1);
    rdata_v = 32'h0000_1234; rresp_v = 2'b10;
    push_txn(1, 32'h2000_0004, 32'h0000_1234, 1'b1);
    g0 = grant_seen; r0 = resp_seen;
    req_addr  = {32'h2000_000C, 32'h2000_0008, 32'h2000_0004, 32'h2000_0000};
    req_valid = 4'b0010;
    wait_grants(g0 + 1, 20, "err_grant_timeout");
    #1 req_valid = '0;
    wait_resps(r0 + 1, 20, "err_resp_timeout");
    repeat (3) @(posedge clk);
    #1;
    check("hold_resp_data", 64'(resp_data), 64'h1234);
    check("hold_resp_err", 64'(resp_err), 64'd1);
    check("hold_resp_id", 64'(resp_id), 64'd1);
    rresp_v = 2'b00;

    // Reset while waiting in DATA: abort silently, priority restarts at 0.
    @(posedge clk); #1;
    begin_test(0);
    r_delay = 20;
    rdata_v = 32'h0000_7777;
    exp_grant.push_back(0);
    exp_addr.push_back(32'h3000_0000);
    g0 = grant_seen;
    req_addr  = {32'h3000_000C, 32'h3000_0008, 32'h3000_0004, 32'h3000_0000};
    req_valid = 4'b0001;
    wait_grants(g0 + 1, 20, "abort_grant_timeout");
    #1 req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!RREADY && n < 20);
    if (!RREADY) fail_msg("abort_rready_timeout");
    rst = 1'b0;
    r0 = resp_seen;
    #1;
    check("abort_rready", 64'(RREADY), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_resp_valid", 64'(resp_valid), 64'd0);
    r_delay = 0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(posedge clk);
    check("abort_no_resp", 64'(resp_seen - r0), 64'd0);

    #1;
    begin_test(1);
    rdata_v = 32'h1111_2222;
    push_txn(1, 32'h4000_0004, 32'h1111_2222, 1'b0);
    push_txn(3, 32'h4000_000C, 32'h1111_2222, 1'b0);
    g0 = grant_seen; r0 = resp_seen;
    req_addr  = {32'h4000_000C, 32'h4000_0008, 32'h4000_0004, 32'h4000_0000};
    req_valid = 4'b1010;
    wait_grants(g0 + 2, 20, "post_rst_grant_timeout");
    #1 req_valid = '0;
    wait_resps(r0 + 2, 20, "post_rst_resp_timeout");

    // Wrap: last grant 3, requesters 0 and 3 -> 0 then 3.
    @(posedge clk); #1;
    begin_test(1);
    rdata_v = 32'h6666_0000;
    push_txn(0, 32'h6000_0000, 32'h6666_0000, 1'b0);
    push_txn(3, 32'h6000_000C, 32'h6666_0000, 1'b0);
    g0 = grant_seen; r0 = resp_seen;
    req_addr  = {32'h6000_000C, 32'h6000_0008, 32'h6000_0004, 32'h6000_0000};
    req_valid = 4'b1001;
    wait_grants(g0 + 2, 20, "wrap_grant_timeout");
    #1 req_valid = '0;
    wait_resps(r0 + 2, 20, "wrap_resp_timeout");

    repeat (5) @(posedge clk);
    check("left_grants", 64'(exp_grant.size()), 64'd0);
    check("left_addrs", 64'(exp_addr.size()), 64'd0);
    check("left_resps", 64'(exp_resp.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axil_rd_arbiter.md
AXIL_RD_ARBITER -- requirements
Module: axil_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of read requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, AXI4-Lite data width.
REQ-004 SHALL have parameter ID_WIDTH, default $clog2(NUM_REQ), requester index width.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester read request.
REQ-008 SHALL have port req_addr  input  NUM_REQ*ADDR_WIDTH  packed request addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port req_ready  output  NUM_REQ  one-hot request accept.
REQ-010 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port resp_id  output  ID_WIDTH  index of the requester being answered.
REQ-012 SHALL have port resp_data  output  DATA_WIDTH  read data.
REQ-013 SHALL have port resp_err  output  1  high when captured RRESP != 2'b00.
REQ-014 SHALL have ports ARADDR out ADDR_WIDTH, ARVALID out 1, ARREADY in 1: AXI4-Lite read address channel.
REQ-015 SHALL have ports RDATA in DATA_WIDTH, RRESP in 2, RVALID in 1, RREADY out 1: AXI4-Lite read data channel.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, DATA, RESP; one transaction outstanding at most.
REQ-018 IDLE: req_ready SHALL be combinational, one-hot on the round-robin winner when any req_valid is high, else all zero; outside IDLE req_ready SHALL be all zero.
REQ-019 Round-robin: search starts at (last_grant+1) mod NUM_REQ and wraps; last_grant updates only on an accepted handshake (req_valid & req_ready).
REQ-020 On handshake SHALL latch the winner's address and index, then move to ADDR the next cycle.
REQ-021 ADDR: ARVALID SHALL be 1 and ARADDR the latched address, both stable until the cycle ARVALID & ARREADY are both high; then move to DATA.
REQ-022 ARVALID SHALL NOT depend combinationally on ARREADY; ARREADY high before ARVALID SHALL NOT complete a transfer.
REQ-023 DATA: RREADY SHALL be 1; on RVALID & RREADY SHALL capture RDATA and RRESP, then move to RESP.
REQ-024 RESP: resp_valid SHALL be 1 for exactly one cycle with resp_id = latched index, resp_data = captured RDATA, resp_err = (RRESP != 0); then move to IDLE.
REQ-025 resp_data SHALL hold the captured RDATA even on error; resp_id/resp_data/resp_err SHALL hold value until the next RESP.
REQ-026 Latency with ARREADY and RVALID tied high: request accepted cycle 0, ARVALID cycle 1, RREADY cycle 2, resp_valid cycle 3; minimum 4 cycles between accepts.
REQ-027 A requester dropping req_valid before handshake SHALL lose the grant with no side effect; requests arriving outside IDLE SHALL wait.
REQ-028 Any width/out-of-range index SHALL never be granted; NUM_REQ not a power of two SHALL wrap correctly.

Reset
REQ-029 rst low SHALL immediately force state IDLE, ARVALID=0, RREADY=0, resp_valid=0, req_ready=0, busy=0, ARADDR=0, resp_id=0, resp_data=0, resp_err=0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-030 Reset mid-transaction SHALL abort with no response; first grant after release follows REQ-029 priority.

Verification
REQ-031 Single request: req_valid=4'b0100, addr 0x0000_0010, ARREADY=1, RVALID=1 RDATA=0xDEAD_BEEF RRESP=0 -> ARADDR=0x10, resp_id=2, resp_data=0xDEADBEEF, resp_err=0, resp_valid cycle 3.
REQ-032 Contention: req_valid=4'b1111 held -> grant order 0,1,2,3,0 across five transactions.
REQ-033 Backpressure: ARREADY low 5 cycles, RVALID delayed 7 cycles -> ARVALID/ARADDR stable throughout, RREADY held, exactly one resp_valid.
REQ-034 Error: RRESP=2'b10 RDATA=0x1234 -> resp_err=1, resp_data=0x1234.
REQ-035 Reset in DATA state -> RREADY=0 and busy=0 same cycle, no resp_valid; next req_valid=4'b1010 grants requester 1.
REQ-036 Wrap: last grant 3, req_valid=4'b1001 -> requester 0 granted, then requester 3.
